alu_req_ctrl: RTL and testbench
===============================

# alu_req_ctrl

Request/response controller for the registered 4-bit ALU datapath: the initiating side of that ALU's operand/op/result interface. It accepts one operation at a time over a valid/ready request channel, drives the ALU operand and op ports from held registers, accounts for the ALU's one-cycle registered latency, and returns the result over a valid/ready response channel. Illegal op codes are rejected locally with an error response and are never issued to the ALU.

## Interface
- Bits, 4: operand/result width; must match the ALU instance.
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low; sampled on the rising edge of clk.
- req_val  input  1  request valid.
- req_rdy  output  1  request ready; high only in IDLE.
- req_a  input  Bits  operand a.
- req_b  input  Bits  operand b.
- req_op  input  2  op code from aluops.h: OP_ADD=2'd0, OP_SUB=2'd1, OP_SHIFT=2'd2; 2'd3 illegal.
- resp_val  output  1  response valid.
- resp_rdy  input  1  response ready.
- resp_result  output  Bits  result; 0 when resp_err=1.
- resp_err  output  1  illegal op flagged.
- alu_a  output  Bits  to ALU a.
- alu_b  output  Bits  to ALU b.
- alu_op  output  2  to ALU op.
- alu_result  input  Bits  from ALU registered result.
- ops_done  output  8  count of completed response handshakes (err included), wraps 255->0.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset state IDLE.
- IDLE: req_rdy=1. On req_val&&req_rdy: capture req_a/b/op into operand regs. Legal op -> ISSUE. Illegal op (2'd3) -> RESP with err_reg=1, result_reg=0; ALU ports not updated.
- ISSUE: alu_a/alu_b/alu_op driven from operand regs (they hold operand regs in every state); ALU captures result at end of this cycle. -> WAIT.
- WAIT: alu_result valid; result_reg<=alu_result, err_reg<=0. -> RESP.
- RESP: resp_val=1, resp_result=result_reg, resp_err=err_reg, all stable until handshake. On resp_val&&resp_rdy: ops_done+1 (mod 256), -> IDLE.
- Only one transaction in flight; req_rdy=0 in ISSUE, WAIT, RESP. Request inputs ignored outside IDLE.
- Arithmetic (performed by the ALU, checked by bench): ADD/SUB mod 2^Bits; SHIFT = a<<b, b full width, result 0 for b>=Bits.
- Reset (reset==0 at a rising edge), including mid-transaction: state IDLE, operand regs 0 (so alu_a=alu_b=0, alu_op=0), result_reg=0, err_reg=0, ops_done=0; in-flight transaction dropped, no response produced. The ALU shares this reset.

## Timing
- Reset values: req_rdy=1, resp_val=0, resp_result=0, resp_err=0, alu_a=0, alu_b=0, alu_op=0, ops_done=0.
- Legal op accepted at edge ending cycle N: ISSUE in N+1, WAIT in N+2, resp_val=1 from N+3.
- Illegal op accepted at end of N: resp_val=1 in N+1.
- Response handshake at end of cycle M: resp_val=0 and req_rdy=1 in M+1; next request accepted no earlier than end of M+1. Minimum legal-op period 4 cycles with resp_rdy held high.
- resp_rdy may be high before resp_val; no effect outside RESP.
- resp_val, req_rdy, resp_* are registered-state decodes, no combinational path from req_* or resp_rdy to any output.

## Test plan
- Reset then ADD a=4'd7,b=4'd5, resp_rdy=1 -> resp_val in cycle 3 after accept, resp_result=4'd12, resp_err=0, ops_done=1.
- SUB a=4'd3,b=4'd5, then SHIFT a=4'd3,b=4'd2, then SHIFT a=4'd1,b=4'd4 -> results 4'd14, 4'd12, 4'd0; req_rdy low during each transaction.
- req_op=2'd3 with a=4'd9 -> resp_val next cycle, resp_err=1, resp_result=0, alu_op/alu_a unchanged from previous legal op.
- ADD 4'd15+4'd1 with resp_rdy=0 for 5 cycles after resp_val -> resp_result=4'd0 held stable, req_rdy=0, req_val pulses ignored; release -> req_rdy=1 next cycle.
- Assert reset in WAIT -> next cycle IDLE, resp_val never asserts for that transaction, all outputs at reset values, ops_done=0.
- 256 back-to-back responses -> ops_done wraps to 0.

Source files
------------

// File: rtl/alu_req_ctrl.sv
// alu_req_ctrl: single-outstanding request/response front end for the
// registered ALU datapath. Drives the ALU from held operand registers,
// absorbs the ALU's one-cycle result latency and rejects illegal ops locally.
module alu_req_ctrl #(
  parameter int unsigned Bits = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_val,
  output logic            req_rdy,
  input  logic [Bits-1:0] req_a,
  input  logic [Bits-1:0] req_b,
  input  logic [1:0]      req_op,
  output logic            resp_val,
  input  logic            resp_rdy,
  output logic [Bits-1:0] resp_result,
  output logic            resp_err,
  output logic [Bits-1:0] alu_a,
  output logic [Bits-1:0] alu_b,
  output logic [1:0]      alu_op,
  input  logic [Bits-1:0] alu_result,
  output logic [7:0]      ops_done
);

  typedef enum logic [1:0] {
    OP_ADD   = 2'd0,
    OP_SUB   = 2'd1,
    OP_SHIFT = 2'd2,
    OP_BAD   = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  logic [Bits-1:0] a_reg;
  logic [Bits-1:0] b_reg;
  logic [1:0]      op_reg;
  logic [Bits-1:0] result_reg;
  logic            err_reg;

  // Transaction sequencer: accept, issue to ALU, collect result, respond.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val) begin
            if (req_op == OP_BAD) begin
              // Illegal op never reaches the ALU: operand regs keep the
              // previous legal operation.
              result_reg <= '0;
              err_reg    <= 1'b1;
              state      <= RESP;
            end else begin
              a_reg  <= req_a;
              b_reg  <= req_b;
              op_reg <= req_op;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          result_reg <= alu_result;
          err_reg    <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          if (resp_rdy) begin
            ops_done <= ops_done + 8'd1;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake and datapath outputs decode held state only.
  always_comb begin
    req_rdy     = (state == IDLE);
    resp_val    = (state == RESP);
    resp_result = result_reg;
    resp_err    = err_reg;
    alu_a       = a_reg;
    alu_b       = b_reg;
    alu_op      = op_reg;
  end

endmodule

// File: tb/tb_alu_req_ctrl.sv
// tb_alu_req_ctrl: directed bench for alu_req_ctrl with a registered ALU
// model on the datapath side and a scoreboard of expected responses.
module tb_alu_req_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_val;
  logic       req_rdy;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [1:0] req_op;
  logic       resp_val;
  logic       resp_rdy;
  logic [3:0] resp_result;
  logic       resp_err;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic [3:0] alu_result;
  logic [7:0] ops_done;

  typedef struct packed {
    logic [3:0] result;
    logic       err;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned exp_ops = 0;

  always #5 clk = ~clk;

  alu_req_ctrl #(.Bits(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_result(resp_result),
    .resp_err   (resp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .ops_done   (ops_done)
  );

  // Registered ALU: result of the ports seen at an edge appears after it.
  always_ff @(posedge clk) begin
    if (!reset) alu_result <= '0;
    else begin
      case (alu_op)
        2'd0:    alu_result <= alu_a + alu_b;
        2'd1:    alu_result <= alu_a - alu_b;
        2'd2:    alu_result <= alu_a << alu_b;
        default: alu_result <= '0;
      endcase
    end
  end

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b,
                                 input logic [1:0] op);
    int   r;
    exp_t e;
    case (op)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b) + 16;
      2'd2:    r = (int'(b) >= 4) ? 0 : (int'(a) * (1 << int'(b)));
      default: r = -1;
    endcase
    if (r < 0) begin
      e.result = 4'd0;
      e.err    = 1'b1;
    end else begin
      e.result = 4'(r % 16);
      e.err    = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one request at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    int w = 0;
    while (!req_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("req_rdy_idle", req_rdy, 1);
    req_val = 1'b1;
    req_a   = a;
    req_b   = b;
    req_op  = op;
    sb.push_back(model(a, b, op));
    @(negedge clk);
    req_val = 1'b0;
    req_a   = 4'($urandom);
    req_b   = 4'($urandom);
    req_op  = 2'($urandom);
  endtask

  // Wait (bounded) for the response, check latency and payload, then
  // handshake after `hold` stalled cycles with optional ignored requests.
  task automatic collect(input int lat, input int hold, input bit poke);
    int   cyc = 1;
    exp_t e;
    resp_rdy = (hold == 0);
    while (!resp_val && cyc < 12) begin
      check("req_rdy_busy", req_rdy, 0);
      @(negedge clk);
      cyc++;
    end
    check("resp_latency", cyc, lat);
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    for (int i = 0; i < hold; i++) begin
      check("stall_resp_val", resp_val, 1);
      check("stall_req_rdy", req_rdy, 0);
      check("stall_result", resp_result, e.result);
      req_val = poke && (i % 2 == 0);
      req_a   = 4'($urandom);
      req_b   = 4'($urandom);
      req_op  = 2'd0;
      @(negedge clk);
    end
    req_val = 1'b0;
    check("resp_result", resp_result, e.result);
    check("resp_err", resp_err, e.err);
    resp_rdy = 1'b1;
    @(negedge clk);
    exp_ops = (exp_ops + 1) % 256;
    resp_rdy = 1'b0;
    check("resp_val_drop", resp_val, 0);
    check("req_rdy_back", req_rdy, 1);
    check("ops_done", ops_done, exp_ops);
  endtask

  task automatic check_reset_values();
    check("rst_req_rdy", req_rdy, 1);
    check("rst_resp_val", resp_val, 0);
    check("rst_resp_result", resp_result, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_ops_done", ops_done, 0);
  endtask

  initial begin
    reset    = 1'b0;
    req_val  = 1'b0;
    req_a    = '0;
    req_b    = '0;
    req_op   = '0;
    resp_rdy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_reset_values();

    // ADD with resp_rdy already high: response three cycles after accept.
    send(4'd7, 4'd5, 2'd0);
    collect(3, 0, 1'b0);

    // SUB wrap, shifts including shift amount equal to width.
    send(4'd3, 4'd5, 2'd1);
    collect(3, 0, 1'b0);
    send(4'd3, 4'd2, 2'd2);
    collect(3, 0, 1'b0);
    send(4'd1, 4'd4, 2'd2);
    collect(3, 0, 1'b0);

    // Illegal op: immediate error response, ALU ports keep last legal op.
    send(4'd9, 4'd6, 2'd3);
    check("bad_alu_op", alu_op, 2);
    check("bad_alu_a", alu_a, 1);
    check("bad_alu_b", alu_b, 4);
    collect(1, 0, 1'b0);

    // ADD overflow with a 5-cycle stall and ignored request pulses.
    send(4'd15, 4'd1, 2'd0);
    collect(3, 5, 1'b1);
    check("stall_alu_a_kept", alu_a, 15);
    check("stall_sb_empty", sb.size(), 0);

    // Reset while the ALU result is being collected: transaction dropped.
    send(4'd6, 4'd3, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    reset   = 1'b1;
    exp_ops = 0;
    check_reset_values();
    for (int i = 0; i < 4; i++) begin
      check("drop_no_resp", resp_val, 0);
      @(negedge clk);
    end

    // 256 back-to-back responses: counter wraps to 0.
    for (int i = 0; i < 256; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      send(4'($urandom), 4'($urandom), op);
      collect((op == 2'd3) ? 1 : 3, 0, 1'b0);
      if (i == 254) check("ops_done_255", ops_done, 255);
    end
    check("ops_done_wrap", ops_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
